// File: rtl/bwt_mem_req_serializer.sv
// ----------------------------------------------------------------------------
// bwt_mem_req_serializer
//
// Buffers k/l line-address pairs from the backward data path in a FIFO.
// Each pair is turned into one or two single-address, tagged memory
// transactions. A pair whose two addresses name the same line is collapsed
// into one transaction that serves both k and l.
//
// Handshake: a transaction transfers on a cycle where mem_req_valid and
// mem_req_ready are both 1. While valid is high and ready is low, addr and
// tag hold steady, and valid only drops after a transfer or on reset.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   request_valid   upstream issues an (addr_k, addr_l, read_num) pair
//   addr_k, addr_l  line addresses for the k and l occurrence counts
//   read_num        read tag carried into the transaction tag
//   stall_req       registered almost-full flag, stalls the pipeline
//   mem_req_valid   transaction valid
//   mem_req_addr    transaction line address
//   mem_req_tag     {read_num, sel (0=k, 1=l), dup (1=serves k and l)}
//   mem_req_ready   memory accepts the transaction
//   overflow_err    sticky: a pair arrived while the FIFO was full
//   issued_cnt      accepted transactions, wraps at 2^32
//   dup_cnt         collapsed pairs, wraps at 2^32
// ----------------------------------------------------------------------------
module bwt_mem_req_serializer #(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int ADDR_W    = 42,
    parameter int RN_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              request_valid,
    input  logic [ADDR_W-1:0] addr_k,
    input  logic [ADDR_W-1:0] addr_l,
    input  logic [RN_W-1:0]   read_num,
    output logic              stall_req,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [RN_W+1:0]   mem_req_tag,
    input  logic              mem_req_ready,
    output logic              overflow_err,
    output logic [31:0]       issued_cnt,
    output logic [31:0]       dup_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [RN_W-1:0]   rn;
        logic [ADDR_W-1:0] addr_k;
        logic [ADDR_W-1:0] addr_l;
        logic              dup;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_K = 2'd1,
        SEND_L = 2'd2
    } state_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;
    logic              stall_q, overflow_q;
    logic [31:0]       issued_q, dup_q;

    entry_t            head;
    logic              full, push, pop, xfer;

    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == CNT_W'(DEPTH));
    // A pair arriving while full is dropped even if a pop happens this cycle.
    assign push = request_valid && !full;
    assign xfer = mem_req_valid && mem_req_ready;
    // The head entry retires on its last transaction: l, or the collapsed k.
    assign pop  = xfer && ((state_q == SEND_L) || (state_q == SEND_K && head.dup));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rn: read_num, addr_k: addr_k, addr_l: addr_l,
                                 dup: (addr_k == addr_l)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            issued_q   <= '0;
            dup_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            stall_q <= (count_d >= CNT_W'(DEPTH - AF_MARGIN));
            if (request_valid && full) overflow_q <= 1'b1;
            if (xfer) issued_q <= issued_q + 32'd1;
            if (pop && state_q == SEND_K) dup_q <= dup_q + 32'd1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. After a pop, count_d already includes any same-cycle
    // push, so the next entry starts with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = SEND_K;
            end
            SEND_K: begin
                if (mem_req_ready) begin
                    if (head.dup) begin
                        state_d = (count_d != '0) ? SEND_K : IDLE;
                    end else begin
                        state_d = SEND_L;
                    end
                end
            end
            SEND_L: begin
                if (mem_req_ready) begin
                    state_d = (count_d != '0) ? SEND_K : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Address and tag are forced to zero when idle.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_tag   = '0;
        case (state_q)
            SEND_K: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = head.addr_k;
                mem_req_tag   = {head.rn, 1'b0, head.dup};
            end
            SEND_L: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = head.addr_l;
                mem_req_tag   = {head.rn, 1'b1, 1'b0};
            end
            default: ;
        endcase
    end

    assign stall_req    = stall_q;
    assign overflow_err = overflow_q;
    assign issued_cnt   = issued_q;
    assign dup_cnt      = dup_q;

endmodule

// File: doc/bwt_mem_req_serializer.md
Name: bwt_mem_req_serializer

Overview:
- Sits directly downstream of the backward data path. It consumes that stage's per-cycle memory request: `request_valid`, `addr_k`, `addr_l` and `read_num`.
- Buffers each request pair in a FIFO and serializes it into single-address, tagged transactions on a ready/valid memory request port.
- Collapses a pair into one transaction when both addresses hit the same line.
- Back-pressures the pipeline through `stall_req` when the buffer nears full.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- AF_MARGIN, 4: `stall_req` asserts when occupancy >= DEPTH-AF_MARGIN.
- ADDR_W, 42: memory line address width.
- RN_W, 9: read_num width; must match `READ_NUM_WIDTH`.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- request_valid  in  1  backward stage issues a k/l pair this cycle.
- addr_k  in  ADDR_W  line address for k occurrence counts.
- addr_l  in  ADDR_W  line address for l occurrence counts.
- read_num  in  RN_W  read tag of the request.
- stall_req  out  1  almost-full; drives pipeline stall.
- mem_req_valid  out  1  transaction valid.
- mem_req_addr  out  ADDR_W  transaction address.
- mem_req_tag  out  RN_W+2  {read_num, sel(0=k,1=l), dup(1=serves both k and l)}.
- mem_req_ready  in  1  memory accepts the transaction this cycle.
- overflow_err  out  1  sticky; a push was attempted while full.
- issued_cnt  out  32  count of accepted memory transactions.
- dup_cnt  out  32  count of collapsed pairs.

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, occupancy 0, FSM=IDLE, all outputs 0. Reset mid-operation discards all buffered and in-flight pairs; no transaction is presented on the cycle after reset.
- FIFO entry is {read_num, addr_k, addr_l, dup}.
  - dup = (addr_k == addr_l), full-width compare, computed at push.
- Push occurs when request_valid=1 and occupancy<DEPTH.
  - If request_valid=1 while full: entry dropped, overflow_err set to 1 until reset.
- Pop occurs only on the final transaction of the head entry, when mem_req_ready=1.
- Push and pop in the same cycle: occupancy unchanged, both take effect. A push into an empty FIFO and a pop cannot coincide.
- stall_req is registered and equals (occupancy >= DEPTH-AF_MARGIN) computed from the post-edge occupancy.
  - With AF_MARGIN >= 2, pipeline requests already in flight still fit.
- FSM states:
  - IDLE: mem_req_valid=0. Go to SEND_K if occupancy != 0.
  - SEND_K: mem_req_valid=1, addr=head.addr_k, tag={rn,0,head.dup}.
    - On ready with dup=1: pop; dup_cnt+1; go to SEND_K if occupancy after pop is nonzero (including a same-cycle push), else IDLE.
    - On ready with dup=0: go to SEND_L.
    - No ready: hold.
  - SEND_L: mem_req_valid=1, addr=head.addr_l, tag={rn,1,0}.
    - On ready: pop; next state follows the same rule as SEND_K.
    - No ready: hold.
- While mem_req_valid=1 and mem_req_ready=0, addr and tag stay stable. Valid never drops without a handshake, except on reset.
- issued_cnt increments by 1 on every valid&&ready; both counters wrap modulo 2^32.
- Latency: a pair pushed at edge E into an empty FIFO with FSM in IDLE gives mem_req_valid=1 in the cycle after edge E+1. Back-to-back entries issue with no bubble.
- Throughput: 1 transaction/cycle. A non-dup pair takes 2 cycles; a dup pair takes 1.
- Ordering: strict FIFO. k is always issued before l for the same entry.

Test Plan:
- Single pair, addr_k=0x100, addr_l=0x1A0, read_num=5, ready held 1 -> two transactions on consecutive cycles: (0x100, tag={5,0,0}) then (0x1A0, tag={5,1,0}); first valid 2 edges after push; issued_cnt=2, then IDLE.
- Dup pair, addr_k=addr_l=0x3FF, read_num=7 -> exactly one transaction (0x3FF, {7,0,1}); dup_cnt=1, issued_cnt=1.
- Ready held 0 for 5 cycles mid-SEND_L -> addr/tag unchanged and valid held high all 5 cycles; after ready rises, the next entry's k request follows with no bubble.
- Push 13 pairs with ready=0, DEPTH=16 -> stall_req=1 after the 12th push. Push 4 more -> 16th accepted, 17th dropped, overflow_err=1. Then drain with ready=1 -> 16 entries' transactions in order, stall_req falls when occupancy <12.
- Push and pop on the same edge at occupancy 12 -> occupancy stays 12, stall_req stays 1.
- Assert rst with 6 entries buffered and FSM in SEND_L -> next cycle mem_req_valid=0, stall_req=0, counters=0, overflow_err=0. A new push afterwards issues normally.
